multicycle_ctrl: RTL and testbench

- Moore/Mealy control FSM that sequences the Lab3 multicycle datapath, built from the 2/4-input muxes and enable-gated registers.
- Drives every mux select and register write enable, and handshakes with a variable-latency memory through mem_ready.
- Counts retired instructions for performance checks.

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 128 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: handshake and control bundle between the multicycle controller and its datapath/memory.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;
  modport master (
    input  run, opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, illegal_op, instr_count
  );
  modport slave (
    output run, opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, illegal_op, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM sequencing the multicycle datapath, with a retired-instruction counter.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_EXEC     = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;
  localparam logic [5:0] op_lw    = 6'b100011;
  localparam logic [5:0] op_sw    = 6'b101011;
  localparam logic [5:0] op_rtype = 6'b000000;
  localparam logic [5:0] op_beq   = 6'b000100;
  localparam logic [5:0] op_j     = 6'b000010;
  localparam logic [5:0] op_addi  = 6'b001000;
  localparam logic [CNT_W-1:0] cnt_one = 1;
  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             retire;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cur <= S_RESET;
    else cur <= nxt;
  always_comb begin
    nxt = S_RESET;
    case (cur)
      S_RESET:  nxt = bus.run ? S_FETCH : S_RESET;
      S_FETCH:  nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: nxt = (bus.opcode == op_lw || bus.opcode == op_sw) ? S_MEMADR :
                      (bus.opcode == op_rtype) ? S_EXEC :
                      (bus.opcode == op_beq)   ? S_BRANCH :
                      (bus.opcode == op_j)     ? S_JUMP :
                      (bus.opcode == op_addi)  ? S_ADDI_EX : S_ILLEGAL;
      S_MEMADR: nxt = (bus.opcode == op_lw) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = S_RTYPE_WB;
      S_ADDI_EX: nxt = S_ADDI_WB;
      S_MEMWB, S_RTYPE_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_ILLEGAL: nxt = S_FETCH;
      default:  nxt = S_RESET;
    endcase
  end
  // IRWrite/PCWrite in FETCH follow mem_ready so the IR and PC update only on the completing cycle
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'd0;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'd0;
    bus.illegal_op  = 1'b0;
    case (cur)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'd1;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: bus.ALUSrcB = 2'd3;
      S_MEMADR, S_ADDI_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_RTYPE_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'd1;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'd2;
      end
      S_ADDI_WB: bus.RegWrite = 1'b1;
      S_ILLEGAL: bus.illegal_op = 1'b1;
      default: bus.illegal_op = 1'b0;
    endcase
  end
  assign retire = (cur == S_MEMWB) || (cur == S_RTYPE_WB) || (cur == S_BRANCH) ||
                  (cur == S_JUMP) || (cur == S_ADDI_WB) || (cur == S_MEMWR && bus.mem_ready);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (retire) cnt <= cnt + cnt_one;
  assign bus.state       = cur;
  assign bus.instr_count = cnt;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level path model checked every cycle, plus literal spot checks.
module tb_multicycle_ctrl;
  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, pcs;
    logic ill;
  } ctl_t;
  logic       clk = 0, reset = 0, run = 0, mem_ready = 0;
  logic [5:0] opcode = 0;
  int         n_chk = 0, n_fail = 0, exp_st = 0;
  bit         chk = 0;
  logic [31:0] cnt_m = 0;
  ctl_t       act, act2;
  always #5 clk = ~clk;
  multicycle_ctrl_if #(.CNT_W(32)) bus ();
  multicycle_ctrl_if #(.CNT_W(2))  bus2 ();
  assign bus.run = run;
  assign bus.opcode = opcode;
  assign bus.mem_ready = mem_ready;
  assign bus2.run = run;
  assign bus2.opcode = opcode;
  assign bus2.mem_ready = mem_ready;
  multicycle_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  multicycle_ctrl #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2.master));
  assign act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.PCSource, bus.illegal_op};
  assign act2 = {bus2.PCWrite, bus2.PCWriteCond, bus2.IorD, bus2.MemRead, bus2.MemWrite, bus2.IRWrite,
                 bus2.MemtoReg, bus2.RegDst, bus2.RegWrite, bus2.ALUSrcA, bus2.ALUSrcB, bus2.ALUOp,
                 bus2.PCSource, bus2.illegal_op};
  // control word each named state must present; FETCH write enables track mem_ready
  function automatic ctl_t ctl_of(input int st, input logic mr);
    ctl_t c;
    c = '0;
    case (st)
      1: begin c.mrd = 1; c.asb = 1; c.irw = mr; c.pcw = mr; end
      2: c.asb = 3;
      3: begin c.asa = 1; c.asb = 2; end
      4: begin c.mrd = 1; c.iord = 1; end
      5: begin c.rw = 1; c.m2r = 1; end
      6: begin c.mwr = 1; c.iord = 1; end
      7: begin c.asa = 1; c.aop = 2; end
      8: begin c.rw = 1; c.rdst = 1; end
      9: begin c.asa = 1; c.aop = 1; c.pcwc = 1; c.pcs = 1; end
      10: begin c.pcw = 1; c.pcs = 2; end
      11: begin c.asa = 1; c.asb = 2; end
      12: c.rw = 1;
      13: c.ill = 1;
      default: c = '0;
    endcase
    return c;
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask
  always @(negedge clk)
    if (chk) begin
      check("state", {28'd0, bus.state}, exp_st);
      check("ctl", {15'd0, act}, {15'd0, ctl_of(exp_st, mem_ready)});
      check("count", bus.instr_count, cnt_m);
      check("state2", {28'd0, bus2.state}, exp_st);
      check("ctl2", {15'd0, act2}, {15'd0, ctl_of(exp_st, mem_ready)});
      check("count2", {30'd0, bus2.instr_count}, {30'd0, cnt_m[1:0]});
    end
  task automatic step(input int st, input logic mr, input bit ret);
    mem_ready = mr;
    exp_st = st;
    chk = 1;
    @(posedge clk);
    #1;
    if (ret) cnt_m = cnt_m + 1;
  endtask
  // one instruction as a path of states: fw fetch stalls, mw memory-phase stalls
  task automatic instr(input logic [5:0] op, input int fw, input int mw);
    opcode = op;
    repeat (fw) step(1, 0, 0);
    step(1, 1, 0);
    step(2, 1, 0);
    case (op)
      6'b100011: begin step(3, 1, 0); repeat (mw) step(4, 0, 0); step(4, 1, 0); step(5, 0, 1); end
      6'b101011: begin step(3, 0, 0); repeat (mw) step(6, 0, 0); step(6, 1, 1); end
      6'b000000: begin step(7, 1, 0); step(8, 1, 1); end
      6'b000100: step(9, 1, 1);
      6'b000010: step(10, 0, 1);
      6'b001000: begin step(11, 1, 0); step(12, 1, 1); end
      default: step(13, 1, 0);
    endcase
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {28'd0, bus.state}, 32'd0);
    check("rst_ctl", {15'd0, act}, 32'd0);
    check("rst_count", bus.instr_count, 32'd0);
    reset = 1;
    step(0, 0, 0);
    step(0, 1, 0);
    run = 1;
    step(0, 0, 0);
    check("run_to_fetch", {28'd0, bus.state}, 32'd1);
    instr(6'b100011, 0, 0);
    check("lw_count", bus.instr_count, 32'd1);
    instr(6'b101011, 0, 2);
    check("sw_count", bus.instr_count, 32'd2);
    run = 0;
    instr(6'b000000, 4, 0);
    instr(6'b000100, 0, 0);
    instr(6'b000010, 0, 0);
    instr(6'b001000, 0, 0);
    instr(6'b111111, 0, 0);
    check("mix_count", bus.instr_count, 32'd6);
    check("wrap_count2_a", {30'd0, bus2.instr_count}, 32'd2);
    instr(6'b100011, 1, 1);
    instr(6'b000010, 0, 0);
    check("count_8", bus.instr_count, 32'd8);
    check("wrap_count2_b", {30'd0, bus2.instr_count}, 32'd0);
    opcode = 6'b100011;
    step(1, 1, 0);
    step(2, 1, 0);
    step(3, 1, 0);
    chk = 0;
    mem_ready = 0;
    #2;
    check("memrd_before", {31'd0, bus.MemRead}, 32'd1);
    reset = 0;
    #1;
    check("memrd_async", {31'd0, bus.MemRead}, 32'd0);
    check("async_state", {28'd0, bus.state}, 32'd0);
    check("async_count", bus.instr_count, 32'd0);
    cnt_m = 0;
    run = 0;
    @(posedge clk);
    #3;
    reset = 1;
    @(posedge clk);
    #1;
    step(0, 1, 0);
    run = 1;
    step(0, 0, 0);
    instr(6'b000010, 0, 0);
    check("post_reset_count", bus.instr_count, 32'd1);
    chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
